operand_sequencer: RTL and testbench

Operand sequencer sitting directly upstream of the 4-bit ripple-carry adder. It captures two operands from a shared 4-bit data input on successive load presses, presents them to the adder, and registers the adder's sum and carry one cycle later. An accumulate mode chains results: the previous sum becomes operand A. It also keeps a saturating count of carry-outs for display.

---
 rtl/operand_sequencer_pkg.sv | 14 +
 rtl/operand_sequencer_if.sv | 35 +++
 rtl/operand_sequencer_rising_edge_detect.sv | 20 ++
 rtl/operand_sequencer.sv | 112 +++++++++++
 tb/tb_operand_sequencer.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/operand_sequencer_pkg.sv
// Shared definitions for the operand sequencer and its companion blocks.
package operand_sequencer_pkg;

  localparam int unsigned DEF_WIDTH     = 4;
  localparam int unsigned DEF_CNT_WIDTH = 4;

  typedef enum logic [1:0] {
    S_IDLE_A = 2'd0,
    S_WAIT_B = 2'd1,
    S_CALC   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/operand_sequencer_if.sv
// Operand sequencer bus: user controls, adder hookup and display outputs.
interface operand_sequencer_if
  import operand_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH
);

  logic [WIDTH-1:0]     data_in;
  logic                 load;
  logic                 acc_mode;
  logic                 clear;
  logic [WIDTH-1:0]     a_out;
  logic [WIDTH-1:0]     b_out;
  logic [WIDTH-1:0]     sum_in;
  logic                 cout_in;
  logic [WIDTH-1:0]     result;
  logic                 carry;
  logic                 done;
  logic [1:0]           state_out;
  logic [CNT_WIDTH-1:0] carry_cnt;

  // Environment side: drives controls and the adder return path.
  modport master (
    output data_in, load, acc_mode, clear, sum_in, cout_in,
    input  a_out, b_out, result, carry, done, state_out, carry_cnt
  );

  // Sequencer side.
  modport slave (
    input  data_in, load, acc_mode, clear, sum_in, cout_in,
    output a_out, b_out, result, carry, done, state_out, carry_cnt
  );

endinterface

// File: rtl/operand_sequencer_rising_edge_detect.sv
// One-cycle pulse on each rising edge of a level input (button front end).
module rising_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic pulse
);

  logic in_q;

  // Previous-cycle copy of the input; cleared by reset so a level already
  // high at release is seen as an edge on the first clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) in_q <= 1'b0;
    else       in_q <= in;
  end

  assign pulse = in & ~in_q;

endmodule

// File: rtl/operand_sequencer.sv
// Captures two operands for the external adder, registers its result and
// counts carry-outs (saturating). Accumulate mode feeds the result back as A.
module operand_sequencer
  import operand_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  operand_sequencer_if.slave  bus
);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 carry_q, carry_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ld_edge;

  rising_edge_detect u_load_edge (
    .clk   (clk),
    .reset (reset),
    .in    (bus.load),
    .pulse (ld_edge)
  );

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE_A;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next state and register updates; clear overrides any load edge.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    if (bus.clear) begin
      state_d  = S_IDLE_A;
      a_d      = '0;
      b_d      = '0;
      result_d = '0;
      carry_d  = 1'b0;
      cnt_d    = '0;
    end else begin
      unique case (state_q)
        S_IDLE_A: begin
          if (ld_edge) begin
            a_d     = bus.data_in;
            state_d = S_WAIT_B;
          end
        end
        S_WAIT_B: begin
          if (ld_edge) begin
            b_d     = bus.data_in;
            state_d = S_CALC;
          end
        end
        S_CALC: begin
          result_d = bus.sum_in;
          carry_d  = bus.cout_in;
          if (bus.cout_in && (cnt_q != '1)) cnt_d = cnt_q + CNT_WIDTH'(1);
          state_d  = S_DONE;
        end
        S_DONE: begin
          if (ld_edge) begin
            if (bus.acc_mode) begin
              a_d     = result_q;
              b_d     = bus.data_in;
              state_d = S_CALC;
            end else begin
              a_d     = bus.data_in;
              state_d = S_WAIT_B;
            end
          end
        end
        default: state_d = S_IDLE_A;
      endcase
    end
  end

  // Status outputs decoded from the current state.
  always_comb begin
    bus.done      = (state_q == S_DONE);
    bus.state_out = state_q;
  end

  assign bus.a_out     = a_q;
  assign bus.b_out     = b_q;
  assign bus.result    = result_q;
  assign bus.carry     = carry_q;
  assign bus.carry_cnt = cnt_q;

endmodule

// File: tb/tb_operand_sequencer.sv
// Directed bench for operand_sequencer with a behavioural reference model.
module tb_operand_sequencer;

  localparam int PH_A    = 0;
  localparam int PH_B    = 1;
  localparam int PH_CALC = 2;
  localparam int PH_SHOW = 3;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  operand_sequencer_if #(.WIDTH(4), .CNT_WIDTH(4)) bus ();

  operand_sequencer #(.WIDTH(4), .CNT_WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Bench-side 4-bit adder.
  logic [4:0] full_sum;
  assign full_sum    = {1'b0, bus.a_out} + {1'b0, bus.b_out};
  assign bus.sum_in  = full_sum[3:0];
  assign bus.cout_in = full_sum[4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integers, updated on each clock.
  int m_phase = PH_A;
  int m_a = 0, m_b = 0, m_res = 0, m_carry = 0, m_cnt = 0;
  int m_prev_load = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = PH_A; m_a = 0; m_b = 0; m_res = 0; m_carry = 0; m_cnt = 0;
      m_prev_load = 0;
    end else begin
      int pressed;
      int total;
      pressed = (bus.load == 1'b1 && m_prev_load == 0) ? 1 : 0;
      m_prev_load = (bus.load == 1'b1) ? 1 : 0;
      if (bus.clear) begin
        m_phase = PH_A; m_a = 0; m_b = 0; m_res = 0; m_carry = 0; m_cnt = 0;
      end else if (m_phase == PH_A) begin
        if (pressed != 0) begin m_a = int'(bus.data_in); m_phase = PH_B; end
      end else if (m_phase == PH_B) begin
        if (pressed != 0) begin m_b = int'(bus.data_in); m_phase = PH_CALC; end
      end else if (m_phase == PH_CALC) begin
        total   = m_a + m_b;
        m_res   = total % 16;
        m_carry = total / 16;
        m_cnt   = (m_cnt + m_carry > 15) ? 15 : m_cnt + m_carry;
        m_phase = PH_SHOW;
      end else begin
        if (pressed != 0) begin
          if (bus.acc_mode) begin
            m_a = m_res; m_b = int'(bus.data_in); m_phase = PH_CALC;
          end else begin
            m_a = int'(bus.data_in); m_phase = PH_B;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    chk("a_out",     32'(bus.a_out),     32'(m_a));
    chk("b_out",     32'(bus.b_out),     32'(m_b));
    chk("result",    32'(bus.result),    32'(m_res));
    chk("carry",     32'(bus.carry),     32'(m_carry));
    chk("carry_cnt", 32'(bus.carry_cnt), 32'(m_cnt));
    chk("state_out", 32'(bus.state_out), 32'(m_phase));
    chk("done",      32'(bus.done),      32'(m_phase == PH_SHOW));
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    bus.data_in = d;
    bus.load    = 1'b1;
    tick();
    bus.load    = 1'b0;
    tick();
  endtask

  task automatic do_clear;
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset        = 1'b0;
    bus.load     = 1'b0;
    bus.clear    = 1'b0;
    bus.acc_mode = 1'b0;
    bus.data_in  = '0;
    #1;
    // Reset with load held high.
    reset       = 1'b1;
    bus.load    = 1'b1;
    bus.data_in = 4'd6;
    tick();
    chk("rst_state", 32'(bus.state_out), 32'd0);
    chk("rst_a",     32'(bus.a_out),     32'd0);
    chk("rst_done",  32'(bus.done),      32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("rel_capture_a", 32'(bus.a_out),     32'd6);
    chk("rel_state",     32'(bus.state_out), 32'd1);
    bus.load = 1'b0;
    tick();

    // 3 + 4
    do_clear();
    press(4'd3);
    bus.data_in = 4'd4;
    bus.load    = 1'b1;
    tick();
    chk("calc_state", 32'(bus.state_out), 32'd2);
    chk("calc_done",  32'(bus.done),      32'd0);
    bus.load = 1'b0;
    tick();
    chk("sum7_result", 32'(bus.result),    32'd7);
    chk("sum7_carry",  32'(bus.carry),     32'd0);
    chk("sum7_done",   32'(bus.done),      32'd1);
    chk("sum7_cnt",    32'(bus.carry_cnt), 32'd0);

    // 9 + 8 overflows, then a non-accumulate press reloads A only
    press(4'd9);
    press(4'd8);
    chk("sum17_result", 32'(bus.result),    32'd1);
    chk("sum17_carry",  32'(bus.carry),     32'd1);
    chk("sum17_cnt",    32'(bus.carry_cnt), 32'd1);
    press(4'd2);
    chk("reload_state", 32'(bus.state_out), 32'd1);
    chk("reload_a",     32'(bus.a_out),     32'd2);
    chk("reload_b",     32'(bus.b_out),     32'd8);

    // Accumulate chain
    do_clear();
    press(4'd5);
    press(4'd5);
    chk("acc10_result", 32'(bus.result), 32'd10);
    bus.acc_mode = 1'b1;
    press(4'd7);
    chk("acc17_result", 32'(bus.result), 32'd1);
    chk("acc17_carry",  32'(bus.carry),  32'd1);
    press(4'd15);
    chk("acc16_result", 32'(bus.result),    32'd0);
    chk("acc16_carry",  32'(bus.carry),     32'd1);
    chk("acc16_cnt",    32'(bus.carry_cnt), 32'd2);
    bus.acc_mode = 1'b0;

    // Held load captures once
    do_clear();
    bus.data_in = 4'd4;
    bus.load    = 1'b1;
    tick();
    bus.data_in = 4'd9;
    repeat (19) tick();
    chk("hold_a",     32'(bus.a_out),     32'd4);
    chk("hold_state", 32'(bus.state_out), 32'd1);
    bus.load = 1'b0;
    tick();
    // Load held through CALC has no further effect
    bus.data_in = 4'd6;
    bus.load    = 1'b1;
    repeat (3) tick();
    chk("held_calc_state",  32'(bus.state_out), 32'd3);
    chk("held_calc_result", 32'(bus.result),    32'd10);
    bus.load = 1'b0;
    tick();
    chk("held_calc_stay", 32'(bus.state_out), 32'd3);

    // Carry counter saturation
    do_clear();
    for (int i = 0; i < 17; i++) begin
      press(4'd15);
      press(4'd15);
    end
    chk("sat_cnt",    32'(bus.carry_cnt), 32'd15);
    chk("sat_result", 32'(bus.result),    32'd14);
    do_clear();
    chk("clr_cnt",    32'(bus.carry_cnt), 32'd0);
    chk("clr_result", 32'(bus.result),    32'd0);
    chk("clr_a",      32'(bus.a_out),     32'd0);
    chk("clr_b",      32'(bus.b_out),     32'd0);
    chk("clr_state",  32'(bus.state_out), 32'd0);

    // Asynchronous reset mid-WAIT_B
    press(4'd3);
    chk("preRst_a", 32'(bus.a_out), 32'd3);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("async_a",     32'(bus.a_out),     32'd0);
    chk("async_state", 32'(bus.state_out), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
